reorder_buffer: RTL and testbench
=================================

// Module: reorder_buffer
// PURPOSE
//  Circular in-order reorder buffer; the producing end of the retire interface.
//  Allocates one rob_entry per dispatched instruction and returns its tag.
//  Marks entries ready on execute writeback and presents the oldest entry as rob_head to retire.
//  Pops the head on rob_decrement; clears all state on flush.
// PARAMETERS
//  DEPTH   16                 number of entries; power of two, >=2
//  TAG_W   $clog2(DEPTH)      tag width; tag == slot index
// PORTS
//  clk             in   1              clock, rising edge
//  reset           in   1              asynchronous, active-high
//  dispatch_valid  in   1              allocate dispatch_entry this cycle
//  dispatch_entry  in   rob_entry      new entry; ready/value/tag fields ignored
//  dispatch_tag    out  TAG_W          slot to be used by the next accepted dispatch (= tail)
//  full            out  1              count == DEPTH
//  empty           out  1              count == 0
//  count           out  TAG_W+1        live entries
//  wb_valid        in   1              execute writeback
//  wb_tag          in   TAG_W          slot being completed
//  wb_value        in   MemoryWord     result / branch target
//  wb_flush        in   1              mispredict; copied into ctrl_bits.flush
//  rob_head        out  rob_entry      oldest entry; all-zero when empty
//  rob_decrement   in   1              retire pops head
//  flush           in   1              discard every entry
// BEHAVIOUR
//  - Storage: DEPTH rob_entry regs + valid bit per slot; head, tail ptrs (TAG_W, wrap mod DEPTH); count.
//  - Reset (async): head=tail=0, count=0, all valid=0, all entries zeroed.
//    Outputs: rob_head=0, dispatch_tag=0, empty=1, full=0, count=0.
//  - Dispatch accepted iff dispatch_valid && !full (full from registered count; no same-cycle pop bypass).
//    Accepted dispatch: slot[tail]=dispatch_entry with tag=tail, ready=0, value=0, ctrl_bits.flush=0.
//    Then valid[tail]=1, tail+=1.
//    dispatch_valid while full is dropped silently; upstream stalls on full.
//  - Writeback: if wb_valid && valid[wb_tag]: ready=1, value=wb_value, ctrl_bits.flush=wb_flush.
//    Writeback to an invalid slot is ignored. Any order across slots.
//  - Pop: rob_decrement && !empty -> valid[head]=0, head+=1. rob_decrement when empty is ignored.
//  - Count: +1 accepted dispatch, -1 accepted pop; both in same cycle -> unchanged.
//  - rob_head: combinational from slot[head] when !empty, else 0 (ready=0).
//  - Simultaneous wb and dispatch to same slot: impossible (slot invalid); wb is ignored.
//  - flush: highest priority. Next edge: head=tail=0, count=0, all valid=0.
//    Same-cycle dispatch, wb and pop are all discarded.
//  - Latency: dispatch visible as rob_head one cycle later if buffer was empty.
//    wb visible in rob_head.ready the next cycle (see CONFIGURATION).
//  - Wrap: head/tail roll DEPTH-1 -> 0; full/empty come from count only, never from ptr equality.
//  - Reset mid-operation: immediate clear regardless of in-flight handshakes.
// CONFIGURATION
//  ROB_WB_BYPASS_EN defined:
//    if wb_valid && wb_tag==head && !empty, rob_head shows ready=1,
//    value=wb_value, ctrl_bits.flush=wb_flush in the same cycle (combinational forward).
//    Retire may pop that cycle; the registered update still occurs.
//  ROB_WB_BYPASS_EN undefined:
//    rob_head reflects registered state only; one extra cycle wb->retire.
// TESTING
//  1 Reset: assert reset mid-cycle -> count=0, empty=1, rob_head=0, dispatch_tag=0 immediately.
//  2 Fill: 16 dispatches, no pops -> tags 0..15; full=1; 17th dispatch dropped, count stays 16.
//  3 Out-of-order wb: dispatch tags 0,1,2; wb tag2 then tag0 (value 0x40) ->
//    head ready next cycle with value 0x40; pop -> head=tag1, ready=0.
//  4 Wrap: steady 1 dispatch + 1 pop per cycle for 40 cycles -> count constant;
//    tail wraps 15->0; tags unique among live entries.
//  5 Flush: 5 live, flush with concurrent dispatch_valid and wb_valid ->
//    next cycle count=0, empty=1, dispatch_tag=0; nothing written.
//  6 Bypass: head tag3 not ready, wb tag3 value 0x1234 in cycle N ->
//    with ROB_WB_BYPASS_EN rob_head.ready=1, value=0x1234 in N; without, in N+1.

Source files
------------

// File: rtl/reorder_buffer_if.sv
`default_nettype none
// ============================================================================
//  rob_pkg / reorder_buffer_if
//  Shared entry types for the reorder buffer and the bundled dispatch,
//  writeback and retire signals that connect it to the pipeline.
//  Revision: 1.0 - initial release
// ============================================================================

package rob_pkg;
  localparam int ROB_TAG_W = 4;

  typedef logic [31:0] memory_word_t;

  typedef struct packed {
    logic flush;
    logic is_branch;
    logic is_store;
    logic reg_write;
  } rob_ctrl_t;

  typedef struct packed {
    logic                 ready;
    memory_word_t         value;
    logic [ROB_TAG_W-1:0] tag;
    rob_ctrl_t            ctrl_bits;
    logic [4:0]           dest;
    memory_word_t         pc;
  } rob_entry_t;
endpackage

interface reorder_buffer_if #(
  parameter int DEPTH = 1 << rob_pkg::ROB_TAG_W,
  parameter int TAG_W = $clog2(DEPTH)
);
  import rob_pkg::*;

  logic             dispatch_valid;
  rob_entry_t       dispatch_entry;
  logic [TAG_W-1:0] dispatch_tag;
  logic             full;
  logic             empty;
  logic [TAG_W:0]   count;
  logic             wb_valid;
  logic [TAG_W-1:0] wb_tag;
  memory_word_t     wb_value;
  logic             wb_flush;
  rob_entry_t       rob_head;
  logic             rob_decrement;
  logic             flush;

  // Reorder buffer side
  modport master (
    input  dispatch_valid, dispatch_entry, wb_valid, wb_tag, wb_value,
           wb_flush, rob_decrement, flush,
    output dispatch_tag, full, empty, count, rob_head
  );

  // Pipeline side (dispatch, execute, retire)
  modport slave (
    output dispatch_valid, dispatch_entry, wb_valid, wb_tag, wb_value,
           wb_flush, rob_decrement, flush,
    input  dispatch_tag, full, empty, count, rob_head
  );
endinterface
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
//  reorder_buffer
//  Circular in-order reorder buffer. Allocates one entry per dispatch at the
//  tail, completes entries on writeback, presents the oldest entry to retire
//  and pops it on rob_decrement. flush discards every live entry.
//  Optional feature macro: ROB_WB_BYPASS_EN (same-cycle writeback forward
//  into rob_head).
//  Revision: 1.0 - initial release
// ============================================================================

module reorder_buffer
  import rob_pkg::*;
#(
  parameter int DEPTH = 1 << ROB_TAG_W,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  wire logic        clk,
  input  wire logic        reset,
  reorder_buffer_if.master bus
);

  localparam logic [TAG_W:0]   DEPTH_CNT = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W-1:0] PTR_ONE   = TAG_W'(1);

  rob_entry_t       slots [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [TAG_W:0]   count;

  logic       is_full;
  logic       is_empty;
  logic       do_dispatch;
  logic       do_pop;
  logic       do_wb;
  rob_entry_t dispatch_fill;
  rob_entry_t head_view;

  // Occupancy comes from the registered count only, never from pointer equality
  assign is_full     = (count == DEPTH_CNT);
  assign is_empty    = (count == '0);
  assign do_dispatch = bus.dispatch_valid && !is_full;
  assign do_pop      = bus.rob_decrement && !is_empty;
  assign do_wb       = bus.wb_valid && valid[bus.wb_tag];

  // New entry: caller payload with tag forced to the slot and completion state cleared
  always_comb begin
    dispatch_fill                 = bus.dispatch_entry;
    dispatch_fill.tag             = ROB_TAG_W'(tail);
    dispatch_fill.ready           = 1'b0;
    dispatch_fill.value           = '0;
    dispatch_fill.ctrl_bits.flush = 1'b0;
  end

  // Pointer, count and per-slot valid bookkeeping; flush wins over everything
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else if (bus.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      // Dispatch and pop never hit the same slot: that needs count 0 or DEPTH
      if (do_dispatch) begin
        valid[tail] <= 1'b1;
        tail        <= tail + PTR_ONE;
      end
      if (do_pop) begin
        valid[head] <= 1'b0;
        head        <= head + PTR_ONE;
      end
      case ({do_dispatch, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage: dispatch fills the tail slot, writeback completes a live slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        slots[i] <= '0;
      end
    end else if (!bus.flush) begin
      if (do_dispatch) begin
        slots[tail] <= dispatch_fill;
      end
      // The tail slot is never valid while a dispatch is accepted, so no overlap
      if (do_wb) begin
        slots[bus.wb_tag].ready           <= 1'b1;
        slots[bus.wb_tag].value           <= bus.wb_value;
        slots[bus.wb_tag].ctrl_bits.flush <= bus.wb_flush;
      end
    end
  end

  // Oldest entry for retire; all-zero when nothing is live
  always_comb begin
    head_view = '0;
    if (!is_empty) begin
      head_view = slots[head];
`ifdef ROB_WB_BYPASS_EN
      // Forward a writeback aimed at the head so retire can pop this cycle
      if (bus.wb_valid && (bus.wb_tag == head)) begin
        head_view.ready           = 1'b1;
        head_view.value           = bus.wb_value;
        head_view.ctrl_bits.flush = bus.wb_flush;
      end
`endif
    end
  end

  assign bus.rob_head     = head_view;
  assign bus.dispatch_tag = tail;
  assign bus.full         = is_full;
  assign bus.empty        = is_empty;
  assign bus.count        = count;

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
//  tb_reorder_buffer
//  Directed self-checking bench for reorder_buffer (DEPTH 16).
//  Revision: 1.0 - initial release
// ============================================================================

module tb_reorder_buffer;
  import rob_pkg::*;

  localparam int DEPTH = 16;
`ifdef ROB_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] exp_pc_q [$];
  int          exp_head;
  int          exp_tail;

  reorder_buffer_if #(.DEPTH(DEPTH)) bus ();

  reorder_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Payload with junk in the fields the buffer must overwrite
  function automatic rob_entry_t mk(input logic [31:0] pc);
    rob_entry_t e;
    e                     = '0;
    e.pc                  = pc;
    e.dest                = pc[4:0];
    e.ctrl_bits.reg_write = 1'b1;
    e.ctrl_bits.flush     = 1'b1;
    e.ready               = 1'b1;
    e.value               = 32'hDEAD_BEEF;
    e.tag                 = '1;
    return e;
  endfunction

  task automatic idle_inputs;
    bus.dispatch_valid = 1'b0;
    bus.dispatch_entry = '0;
    bus.wb_valid       = 1'b0;
    bus.wb_tag         = '0;
    bus.wb_value       = '0;
    bus.wb_flush       = 1'b0;
    bus.rob_decrement  = 1'b0;
    bus.flush          = 1'b0;
  endtask

  task automatic dispatch_one(input logic [31:0] pc);
    bus.dispatch_valid = 1'b1;
    bus.dispatch_entry = mk(pc);
    tick();
    bus.dispatch_valid = 1'b0;
  endtask

  task automatic pop_one;
    bus.rob_decrement = 1'b1;
    tick();
    bus.rob_decrement = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // Reset state
    check_val("rst_count", 64'(bus.count), 64'd0);
    check_val("rst_empty", 64'(bus.empty), 64'd1);
    check_val("rst_full", 64'(bus.full), 64'd0);
    check_val("rst_dtag", 64'(bus.dispatch_tag), 64'd0);
    check_val("rst_head_zero", 64'(bus.rob_head == '0), 64'd1);

    // Fill: tags 0..15, then a dropped 17th dispatch
    for (int i = 0; i < DEPTH; i++) begin
      bus.dispatch_valid = 1'b1;
      bus.dispatch_entry = mk(32'h100 + 32'(i));
      check_val("fill_dtag", 64'(bus.dispatch_tag), 64'(i));
      tick();
    end
    bus.dispatch_valid = 1'b0;
    check_val("fill_full", 64'(bus.full), 64'd1);
    check_val("fill_count", 64'(bus.count), 64'd16);
    check_val("fill_empty", 64'(bus.empty), 64'd0);
    dispatch_one(32'h1FF);
    check_val("drop_count", 64'(bus.count), 64'd16);
    check_val("drop_dtag", 64'(bus.dispatch_tag), 64'd0);
    check_val("drop_head_tag", 64'(bus.rob_head.tag), 64'd0);
    check_val("drop_head_pc", 64'(bus.rob_head.pc), 64'h100);
    check_val("head_ready_clr", 64'(bus.rob_head.ready), 64'd0);
    check_val("head_value_clr", 64'(bus.rob_head.value), 64'd0);
    check_val("head_flush_clr", 64'(bus.rob_head.ctrl_bits.flush), 64'd0);

    // Reset asserted mid-cycle clears outputs without waiting for an edge
    #3;
    reset = 1'b1;
    #1;
    check_val("arst_count", 64'(bus.count), 64'd0);
    check_val("arst_empty", 64'(bus.empty), 64'd1);
    check_val("arst_full", 64'(bus.full), 64'd0);
    check_val("arst_dtag", 64'(bus.dispatch_tag), 64'd0);
    check_val("arst_head_zero", 64'(bus.rob_head == '0), 64'd1);
    tick();
    reset = 1'b0;
    tick();

    // Out-of-order writeback: tag2 then tag0
    for (int i = 0; i < 3; i++) dispatch_one(32'h200 + 32'(i));
    bus.wb_valid = 1'b1;
    bus.wb_tag   = 4'd2;
    bus.wb_value = 32'h22;
    bus.wb_flush = 1'b1;
    tick();
    bus.wb_tag   = 4'd0;
    bus.wb_value = 32'h40;
    bus.wb_flush = 1'b0;
    tick();
    bus.wb_valid = 1'b0;
    check_val("ooo_head_tag", 64'(bus.rob_head.tag), 64'd0);
    check_val("ooo_head_ready", 64'(bus.rob_head.ready), 64'd1);
    check_val("ooo_head_value", 64'(bus.rob_head.value), 64'h40);
    pop_one();
    check_val("ooo_pop_tag", 64'(bus.rob_head.tag), 64'd1);
    check_val("ooo_pop_ready", 64'(bus.rob_head.ready), 64'd0);
    check_val("ooo_pop_count", 64'(bus.count), 64'd2);
    pop_one();
    check_val("ooo_t2_tag", 64'(bus.rob_head.tag), 64'd2);
    check_val("ooo_t2_ready", 64'(bus.rob_head.ready), 64'd1);
    check_val("ooo_t2_value", 64'(bus.rob_head.value), 64'h22);
    check_val("ooo_t2_flush", 64'(bus.rob_head.ctrl_bits.flush), 64'd1);
    pop_one();
    check_val("drain_empty", 64'(bus.empty), 64'd1);
    check_val("drain_head_zero", 64'(bus.rob_head == '0), 64'd1);
    // Pop on empty is ignored
    pop_one();
    check_val("pop_empty_count", 64'(bus.count), 64'd0);
    check_val("pop_empty_dtag", 64'(bus.dispatch_tag), 64'd3);

    // Wrap: three live entries, then one dispatch plus one pop per cycle
    exp_head = 3;
    exp_tail = 3;
    for (int k = 0; k < 3; k++) begin
      dispatch_one(32'h1000 + 32'(k));
      exp_pc_q.push_back(32'h1000 + 32'(k));
      exp_tail = (exp_tail + 1) % DEPTH;
    end
    for (int k = 3; k < 43; k++) begin
      bus.dispatch_valid = 1'b1;
      bus.dispatch_entry = mk(32'h1000 + 32'(k));
      bus.rob_decrement  = 1'b1;
      check_val("wrap_head_tag", 64'(bus.rob_head.tag), 64'(exp_head));
      check_val("wrap_head_pc", 64'(bus.rob_head.pc), 64'(exp_pc_q[0]));
      check_val("wrap_dtag", 64'(bus.dispatch_tag), 64'(exp_tail));
      tick();
      void'(exp_pc_q.pop_front());
      exp_pc_q.push_back(32'h1000 + 32'(k));
      exp_head = (exp_head + 1) % DEPTH;
      exp_tail = (exp_tail + 1) % DEPTH;
      check_val("wrap_count", 64'(bus.count), 64'd3);
    end
    bus.dispatch_valid = 1'b0;
    bus.rob_decrement  = 1'b0;

    // Flush with five live entries and concurrent dispatch, writeback and pop
    dispatch_one(32'h2000);
    dispatch_one(32'h2001);
    check_val("pre_flush_count", 64'(bus.count), 64'd5);
    check_val("pre_flush_dtag", 64'(bus.dispatch_tag), 64'd0);
    bus.flush          = 1'b1;
    bus.dispatch_valid = 1'b1;
    bus.dispatch_entry = mk(32'h5555);
    bus.wb_valid       = 1'b1;
    bus.wb_tag         = 4'(exp_head);
    bus.wb_value       = 32'h9999;
    bus.rob_decrement  = 1'b1;
    tick();
    idle_inputs();
    check_val("flush_count", 64'(bus.count), 64'd0);
    check_val("flush_empty", 64'(bus.empty), 64'd1);
    check_val("flush_dtag", 64'(bus.dispatch_tag), 64'd0);
    check_val("flush_head_zero", 64'(bus.rob_head == '0), 64'd1);
    dispatch_one(32'h600);
    check_val("post_flush_tag", 64'(bus.rob_head.tag), 64'd0);
    check_val("post_flush_pc", 64'(bus.rob_head.pc), 64'h600);
    check_val("post_flush_count", 64'(bus.count), 64'd1);

    // Writeback forwarding to a not-yet-ready head at tag 3
    for (int i = 1; i < 4; i++) dispatch_one(32'h600 + 32'(i));
    for (int i = 0; i < 3; i++) pop_one();
    check_val("byp_pre_tag", 64'(bus.rob_head.tag), 64'd3);
    check_val("byp_pre_ready", 64'(bus.rob_head.ready), 64'd0);
    bus.wb_valid = 1'b1;
    bus.wb_tag   = 4'd3;
    bus.wb_value = 32'h1234;
    bus.wb_flush = 1'b0;
    #1;
    check_val("byp_same_ready", 64'(bus.rob_head.ready), 64'(BYP));
    check_val("byp_same_value", 64'(bus.rob_head.value), BYP ? 64'h1234 : 64'd0);
    tick();
    bus.wb_valid = 1'b0;
    check_val("byp_next_ready", 64'(bus.rob_head.ready), 64'd1);
    check_val("byp_next_value", 64'(bus.rob_head.value), 64'h1234);

    // Writeback to an unallocated slot (5) must leave no trace
    bus.wb_valid = 1'b1;
    bus.wb_tag   = 4'd5;
    bus.wb_value = 32'h77;
    tick();
    bus.wb_valid = 1'b0;
    dispatch_one(32'h604);
    dispatch_one(32'h605);
    pop_one();
    pop_one();
    check_val("inv_wb_tag", 64'(bus.rob_head.tag), 64'd5);
    check_val("inv_wb_ready", 64'(bus.rob_head.ready), 64'd0);
    check_val("inv_wb_value", 64'(bus.rob_head.value), 64'd0);
    check_val("inv_wb_count", 64'(bus.count), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
